mem_access_ctrl: RTL and testbench

Memory-stage data access controller for the RISC-V pipeline. It decodes `load_sel_M`/`store_sel_M` into a request/acknowledge transaction toward a variable-latency data memory, stalling the pipeline while the access is outstanding. The block generates byte enables and write-data lane replication, then sign- or zero-extends returned load data. It also flags illegal, misaligned and (optionally) timed-out accesses, replacing the old combinational read/write decode with a multi-cycle handshake master.

---
 rtl/mem_access_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: req/ack master toward a variable-latency data memory.
// Optional MEM_TIMEOUT_EN aborts a request that is not acknowledged within TIMEOUT_CYC cycles.
module mem_access_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        load_sel_M,
    input  logic [2:0]        store_sel_M,
    input  logic [ADDR_W-1:0] addr_M,
    input  logic [31:0]       wdata_M,
    input  logic              flush_M,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_rnw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       load_data_M,
    output logic              stall_M,
    output logic              err_illegal,
    output logic              err_misalign,
    output logic              err_timeout
);

    localparam logic [2:0] SEL_NONE = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;

    logic        load_act, store_act;
    logic        is_illegal, is_access, is_misalign;
    logic [1:0]  size;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [2:0]  ld_sel_q;
    logic [1:0]  off_q;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_comb begin
        // NOTE: every output of this block is given a value before any branch, so no latch is inferred.
        be_next    = 4'b1111;
        wdata_next = wdata_M;
        load_act   = (load_sel_M != SEL_NONE);
        store_act  = (store_sel_M != SEL_NONE);
        size       = load_act ? load_sel_M[1:0] : store_sel_M[1:0];
        is_illegal = !flush_M && ((load_act && store_act)
                   || (load_act && !(load_sel_M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
                   || (store_act && !(store_sel_M inside {3'b000, 3'b001, 3'b010})));
        is_access  = !flush_M && !is_illegal && (load_act || store_act);
        is_misalign = ((size == 2'b01) && addr_M[0])
                   || ((size == 2'b10) && (addr_M[1:0] != 2'b00));
        case (size)
            2'b00: begin
                be_next    = 4'b0001 << addr_M[1:0];
                wdata_next = {4{wdata_M[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << {addr_M[1], 1'b0};
                wdata_next = {2{wdata_M[15:0]}};
            end
            default: ;
        endcase
    end

    // Stores are recorded with ld_sel_q = none so their completion yields zero load data.
    always_comb begin
        rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ld_sel_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_ext = {24'b0, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_ext = {16'b0, rd_half};
            3'b010:  load_ext = mem_rdata;
            default: load_ext = '0;
        endcase
    end

    assign stall_M = !rst && ((state == BUSY) || ((state == IDLE) && (is_access || is_illegal)));

`ifndef MEM_TIMEOUT_EN
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_rnw      <= 1'b1;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            load_data_M  <= '0;
            err_illegal  <= 1'b0;
            err_misalign <= 1'b0;
            ld_sel_q     <= SEL_NONE;
            off_q        <= '0;
`ifdef MEM_TIMEOUT_EN
            err_timeout  <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (is_illegal) begin
                        err_illegal <= 1'b1;
                        load_data_M <= '0;
                        state       <= DONE;
                    end else if (is_access && is_misalign) begin
                        err_misalign <= 1'b1;
                        load_data_M  <= '0;
                        state        <= DONE;
                    end else if (is_access) begin
                        mem_req   <= 1'b1;
                        mem_rnw   <= load_act;
                        mem_addr  <= {addr_M[ADDR_W-1:2], 2'b00};
                        mem_be    <= be_next;
                        mem_wdata <= store_act ? wdata_next : '0;
                        ld_sel_q  <= load_act ? load_sel_M : SEL_NONE;
                        off_q     <= addr_M[1:0];
`ifdef MEM_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        load_data_M <= load_ext;
                        state       <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        mem_req     <= 1'b0;
                        load_data_M <= '0;
                        err_timeout <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    err_illegal  <= 1'b0;
                    err_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                    err_timeout  <= 1'b0;
`endif
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a scoreboard of expected DONE results plus
// per-scenario checks of request fields, stall length and reset behaviour.
module tb_mem_access_ctrl;

    localparam int ADDR_W = 32;
    localparam int TO_CYC = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        load_sel_M = 3'b010;
    logic [2:0]        store_sel_M = 3'b111;
    logic [ADDR_W-1:0] addr_M = '0;
    logic [31:0]       wdata_M = '0;
    logic              flush_M = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              mem_req, mem_rnw;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata, load_data_M;
    logic              stall_M, err_illegal, err_misalign, err_timeout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic        ill;
        logic        mis;
        logic        to;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_stall = 1'b0;
    logic [2:0] load_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .load_sel_M(load_sel_M), .store_sel_M(store_sel_M),
        .addr_M(addr_M), .wdata_M(wdata_M), .flush_M(flush_M),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .load_data_M(load_data_M),
        .stall_M(stall_M), .err_illegal(err_illegal),
        .err_misalign(err_misalign), .err_timeout(err_timeout)
    );

    // A falling stall marks the DONE cycle; its result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && !stall_M) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: DONE seen with empty scoreboard");
                end else begin
                    mon_e = sb.pop_front();
                    if ({load_data_M, err_illegal, err_misalign, err_timeout} !==
                        {mon_e.data, mon_e.ill, mon_e.mis, mon_e.to}) begin
                        errors++;
                        $display("FAIL done_result: got data=%h ill=%b mis=%b to=%b want data=%h ill=%b mis=%b to=%b",
                                 load_data_M, err_illegal, err_misalign, err_timeout,
                                 mon_e.data, mon_e.ill, mon_e.mis, mon_e.to);
                    end
                end
            end
            prev_stall <= stall_M;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_load(logic [2:0] sel, logic [1:0] off, logic [31:0] rd);
        logic [31:0] s;
        s = rd >> (8 * off);
        case (sel)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b101:  return {16'h0, s[15:0]};
            3'b010:  return rd;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(logic [1:0] sz, logic [1:0] off);
        case (sz)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(logic [1:0] sz, logic [31:0] wd);
        case (sz)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Drives one instruction from an IDLE cycle until DONE, acking on BUSY cycle ack_dly (<0: never).
    task automatic run_access(input logic [2:0] lsel, input logic [2:0] ssel,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int ack_dly,
                              output int stall_cnt, output bit req_seen,
                              output logic rnw_s, output logic [3:0] be_s,
                              output logic [31:0] addr_s, output logic [31:0] wdata_s);
        int busy_idx;
        bit done;
        stall_cnt = 0; req_seen = 1'b0; busy_idx = 0; done = 1'b0;
        rnw_s = 1'b0; be_s = '0; addr_s = '0; wdata_s = '0;
        @(posedge clk); #1;
        load_sel_M = lsel; store_sel_M = ssel; addr_M = addr;
        wdata_M = wd; mem_rdata = rd; mem_ack = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (stall_M) begin
                stall_cnt++;
                if (mem_req) begin
                    if (!req_seen) begin
                        req_seen = 1'b1;
                        rnw_s = mem_rnw; be_s = mem_be; addr_s = mem_addr; wdata_s = mem_wdata;
                    end
                    if (busy_idx == ack_dly) mem_ack = 1'b1;
                    busy_idx++;
                end
            end else begin
                done = 1'b1;
            end
        end
        load_sel_M = 3'b111; store_sel_M = 3'b111; mem_ack = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL access_done: got no DONE in 60 cycles want DONE (lsel=%b ssel=%b)", lsel, ssel);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, mem_rnw, mem_be, stall_M} !== {1'b0, 1'b1, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: got req=%b rnw=%b be=%b stall=%b want 0 1 0000 0",
                     mem_req, mem_rnw, mem_be, stall_M);
        end
        checks++;
        if ({mem_addr, mem_wdata, load_data_M} !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h ld=%h want all 0", mem_addr, mem_wdata, load_data_M);
        end
        checks++;
        if ({err_illegal, err_misalign, err_timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_err: got %b want 000", {err_illegal, err_misalign, err_timeout});
        end
        @(posedge clk); #1;
        load_sel_M = 3'b111;
        rst = 1'b0;
    endtask

    task automatic test_lbu();
        int sc; bit rq; logic rnw; logic [3:0] be; logic [31:0] a, w;
        sb.push_back('{32'h0000_0080, 1'b0, 1'b0, 1'b0});
        run_access(3'b100, 3'b111, 32'h103, 32'h0, 32'h80FF_1234, 2, sc, rq, rnw, be, a, w);
        checks++;
        if ({rq, rnw, be, a} !== {1'b1, 1'b1, 4'b1000, 32'h100}) begin
            errors++;
            $display("FAIL lbu_req: got req=%b rnw=%b be=%b addr=%h want 1 1 1000 00000100", rq, rnw, be, a);
        end
        checks++;
        if (sc != 4) begin
            errors++;
            $display("FAIL lbu_stall: got %0d stall cycles want 4", sc);
        end
    endtask

    task automatic test_lh();
        int sc; bit rq; logic rnw; logic [3:0] be; logic [31:0] a, w;
        sb.push_back('{32'hFFFF_8001, 1'b0, 1'b0, 1'b0});
        run_access(3'b001, 3'b111, 32'h102, 32'h0, 32'h8001_0000, 0, sc, rq, rnw, be, a, w);
        checks++;
        if ({rq, rnw, be} !== {1'b1, 1'b1, 4'b1100}) begin
            errors++;
            $display("FAIL lh_req: got req=%b rnw=%b be=%b want 1 1 1100", rq, rnw, be);
        end
        checks++;
        if (sc != 2) begin
            errors++;
            $display("FAIL lh_latency: got %0d stall cycles want 2", sc);
        end
    endtask

    task automatic test_misalign();
        int sc; bit rq; logic rnw; logic [3:0] be; logic [31:0] a, w;
        sb.push_back('{32'h0, 1'b0, 1'b1, 1'b0});
        run_access(3'b001, 3'b111, 32'h101, 32'h0, 32'h0, 0, sc, rq, rnw, be, a, w);
        sb.push_back('{32'h0, 1'b0, 1'b1, 1'b0});
        run_access(3'b111, 3'b010, 32'h302, 32'hCAFE_F00D, 32'h0, 0, sc, rq, rnw, be, a, w);
        checks++;
        if (rq !== 1'b0 || sc != 1) begin
            errors++;
            $display("FAIL sw_misalign: got req_seen=%b stall=%0d want 0 1", rq, sc);
        end
    endtask

    task automatic test_sb();
        int sc; bit rq; logic rnw; logic [3:0] be; logic [31:0] a, w;
        sb.push_back('{32'h0, 1'b0, 1'b0, 1'b0});
        run_access(3'b111, 3'b000, 32'h201, 32'h1234_56AB, 32'hFFFF_FFFF, 0, sc, rq, rnw, be, a, w);
        checks++;
        if ({rq, rnw, be, a, w} !== {1'b1, 1'b0, 4'b0010, 32'h200, 32'hABAB_ABAB}) begin
            errors++;
            $display("FAIL sb_req: got req=%b rnw=%b be=%b addr=%h wdata=%h want 1 0 0010 00000200 abababab",
                     rq, rnw, be, a, w);
        end
    endtask

    task automatic test_illegal();
        int sc; bit rq; logic rnw; logic [3:0] be; logic [31:0] a, w;
        logic [2:0] ls [3] = '{3'b010, 3'b011, 3'b111};
        logic [2:0] ss [3] = '{3'b000, 3'b111, 3'b100};
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{32'h0, 1'b1, 1'b0, 1'b0});
            run_access(ls[i], ss[i], 32'h40, 32'h0, 32'h0, 0, sc, rq, rnw, be, a, w);
            checks++;
            if (rq !== 1'b0 || sc != 1) begin
                errors++;
                $display("FAIL illegal_%0d: got req_seen=%b stall=%0d want 0 1", i, rq, sc);
            end
        end
    endtask

    task automatic test_none();
        @(posedge clk); #1;
        load_sel_M = 3'b111; store_sel_M = 3'b111; mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                load_sel_M = 3'b010; addr_M = 32'h10; flush_M = 1'b1;
            end
            @(negedge clk);
            checks++;
            if ({stall_M, mem_req, err_illegal, err_misalign} !== 4'b0000) begin
                errors++;
                $display("FAIL none_%0d: got stall=%b req=%b ill=%b mis=%b want 0 0 0 0",
                         i, stall_M, mem_req, err_illegal, err_misalign);
            end
        end
        load_sel_M = 3'b111; flush_M = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            int sc, dly; bit rq, st; logic rnw; logic [3:0] be; logic [31:0] a, w;
            logic [2:0] lsel, ssel; logic [1:0] sz, off; logic [31:0] addr, rd, wd;
            st = ($urandom_range(0, 2) == 0);
            if (st) begin
                ssel = 3'($urandom_range(0, 2)); lsel = 3'b111; sz = ssel[1:0];
            end else begin
                lsel = load_codes[$urandom_range(0, 4)]; ssel = 3'b111; sz = lsel[1:0];
            end
            if (sz == 2'b00)      off = 2'($urandom_range(0, 3));
            else if (sz == 2'b01) off = {1'($urandom_range(0, 1)), 1'b0};
            else                  off = 2'b00;
            addr = ($urandom() & 32'hFFFF_FFFC) | {30'h0, off};
            rd = $urandom(); wd = $urandom(); dly = $urandom_range(0, 3);
            sb.push_back('{st ? 32'h0 : ref_load(lsel, off, rd), 1'b0, 1'b0, 1'b0});
            run_access(lsel, ssel, addr, wd, rd, dly, sc, rq, rnw, be, a, w);
            checks++;
            if (sc != 2 + dly || {rq, rnw, be, a} !== {1'b1, !st, ref_be(sz, off), addr & 32'hFFFF_FFFC}) begin
                errors++;
                $display("FAIL b2b_%0d: got stall=%0d req=%b rnw=%b be=%b addr=%h want %0d 1 %b %b %h",
                         i, sc, rq, rnw, be, a, 2 + dly, !st, ref_be(sz, off), addr & 32'hFFFF_FFFC);
            end
            if (st) begin
                checks++;
                if (w !== ref_wdata(sz, wd)) begin
                    errors++;
                    $display("FAIL b2b_wdata_%0d: got %h want %h", i, w, ref_wdata(sz, wd));
                end
            end
        end
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        int sc; bit rq; logic rnw; logic [3:0] be; logic [31:0] a, w;
        sb.push_back('{32'h0, 1'b0, 1'b0, 1'b1});
        run_access(3'b010, 3'b111, 32'h504, 32'h0, 32'hDEAD_BEEF, -1, sc, rq, rnw, be, a, w);
        checks++;
        if (sc != TO_CYC + 1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: got stall=%0d req=%b want %0d 0", sc, mem_req, TO_CYC + 1);
        end
`else
        int cnt;
        cnt = 0;
        @(posedge clk); #1;
        load_sel_M = 3'b010; addr_M = 32'h500;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall_M === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 40 || mem_req !== 1'b1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout_hold: got stall_cycles=%0d req=%b to=%b want 40 1 0",
                     cnt, mem_req, err_timeout);
        end
        @(posedge clk); #1;
        rst = 1'b1; load_sel_M = 3'b111;
        @(posedge clk); #1;
        rst = 1'b0;
`endif
    endtask

    task automatic test_reset_busy();
        @(posedge clk); #1;
        load_sel_M = 3'b010; addr_M = 32'h400; mem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        checks++;
        if ({mem_req, stall_M} !== 2'b11) begin
            errors++;
            $display("FAIL rb_busy: got req=%b stall=%b want 1 1", mem_req, stall_M);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, stall_M} !== 2'b00) begin
            errors++;
            $display("FAIL rb_async: got req=%b stall=%b want 0 0", mem_req, stall_M);
        end
        load_sel_M = 3'b111;
        @(posedge clk); #1;
        rst = 1'b0; mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, stall_M, err_illegal, err_misalign, err_timeout} !== 5'b0 || load_data_M !== 32'h0) begin
            errors++;
            $display("FAIL rb_idle: got req=%b stall=%b errs=%b ld=%h want 0 0 000 00000000",
                     mem_req, stall_M, {err_illegal, err_misalign, err_timeout}, load_data_M);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lbu();
        test_lh();
        test_misalign();
        test_sb();
        test_illegal();
        test_none();
        test_back_to_back();
        test_timeout();
        test_reset_busy();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending results want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
